// File: rtl/hgame_pkg.sv
// Shared types and constants for the Hunch game match controller.
package hgame_pkg;

  // Match sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PLAY,
    SCORE,
    DONE
  } state_t;

  // Round-result codes, bit map [2]=A [1]=B [0]=C.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_A    = 3'b100;
  localparam logic [2:0] RES_B    = 3'b010;
  localparam logic [2:0] RES_C    = 3'b001;
  localparam logic [2:0] RES_DRAW = 3'b111;

endpackage

// File: rtl/hgame_round_timer.sv
// Round stall timer: cleared by load, counts while enabled,
// expire is high on the enabled cycle where the count sits at TIMEOUT_CYC-1.
module hgame_round_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] cnt;

  // Counter: load to zero, advance while enabled, park at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= '0;
    else if (en && !expire)  cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/hgame_match_ctrl.sv
// Match-level sequencer around the Hunch round FSM: resets the round FSM
// between rounds, scores each result, times out stalled rounds and
// declares the match winner(s).
module hgame_match_ctrl
  import hgame_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int MAX_ROUNDS  = 9,
  parameter int TIMEOUT_CYC = 16,
  localparam int SW = $clog2(WIN_SCORE + 1),
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [2:0]    WINNER_DISP,
  output logic          GAME_RST,
  output logic [SW-1:0] SCORE_A,
  output logic [SW-1:0] SCORE_B,
  output logic [SW-1:0] SCORE_C,
  output logic [RW-1:0] ROUND_CNT,
  output logic [2:0]    MATCH_WINNER,
  output logic          MATCH_DONE,
  output logic          BUSY
);

  state_t        state, next_state;
  logic [2:0]    res;
  logic          expire;
  logic [SW-1:0] new_a, new_b, new_c, max_ab, max_s;
  logic [RW-1:0] new_round;
  logic [2:0]    win_mask;
  logic          done_hit;
  logic          clear_match;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s >= SW'(WIN_SCORE)) ? s : s + 1'b1;
  endfunction

  hgame_round_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (state == CLEAR),
    .en     (state == PLAY),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Candidate scores, round count, finish test and winner mask for the SCORE cycle.
  always_comb begin
    new_a     = (res != RES_DRAW && res[2]) ? sat_inc(SCORE_A) : SCORE_A;
    new_b     = (res != RES_DRAW && res[1]) ? sat_inc(SCORE_B) : SCORE_B;
    new_c     = (res != RES_DRAW && res[0]) ? sat_inc(SCORE_C) : SCORE_C;
    new_round = (ROUND_CNT >= RW'(MAX_ROUNDS)) ? ROUND_CNT : ROUND_CNT + 1'b1;
    done_hit  = (new_a == SW'(WIN_SCORE)) || (new_b == SW'(WIN_SCORE)) ||
                (new_c == SW'(WIN_SCORE)) || (new_round == RW'(MAX_ROUNDS));
    max_ab    = (new_a > new_b) ? new_a : new_b;
    max_s     = (max_ab > new_c) ? max_ab : new_c;
    win_mask  = {new_a == max_s, new_b == max_s, new_c == max_s};
  end

  // Next-state logic; ABORT overrides every state.
  always_comb begin
    next_state = state;
    if (ABORT) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (START) next_state = CLEAR;
        CLEAR:   next_state = PLAY;
        PLAY:    if (WINNER_DISP != RES_NONE || expire) next_state = SCORE;
        SCORE:   next_state = done_hit ? DONE : CLEAR;
        DONE:    if (START) next_state = CLEAR;
        default: next_state = IDLE;
      endcase
    end
  end

  // A new match starts on the edge leaving IDLE or DONE for CLEAR.
  always_comb begin
    clear_match = (next_state == CLEAR) && (state == IDLE || state == DONE);
  end

  // Registered datapath: round-FSM reset, result latch, scores, round count, winner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GAME_RST     <= 1'b1;
      res          <= RES_NONE;
      SCORE_A      <= '0;
      SCORE_B      <= '0;
      SCORE_C      <= '0;
      ROUND_CNT    <= '0;
      MATCH_WINNER <= RES_NONE;
    end else begin
      GAME_RST <= (next_state == IDLE) || (next_state == CLEAR) || (next_state == DONE);
      // A real result takes precedence over a coincident timeout.
      if (state == PLAY && next_state == SCORE)
        res <= (WINNER_DISP != RES_NONE) ? WINNER_DISP : RES_DRAW;
      if (clear_match) begin
        SCORE_A      <= '0;
        SCORE_B      <= '0;
        SCORE_C      <= '0;
        ROUND_CNT    <= '0;
        MATCH_WINNER <= RES_NONE;
      end else if (state == SCORE && !ABORT) begin
        SCORE_A   <= new_a;
        SCORE_B   <= new_b;
        SCORE_C   <= new_c;
        ROUND_CNT <= new_round;
        if (next_state == DONE) MATCH_WINNER <= win_mask;
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    MATCH_DONE = (state == DONE);
    BUSY       = (state == CLEAR) || (state == PLAY) || (state == SCORE);
  end

endmodule

// File: tb/tb_hgame_match_ctrl.sv
// Self-checking bench for hgame_match_ctrl: two instances (default limits and
// MAX_ROUNDS=2) share one stimulus; a match-rules model is compared every cycle.
module tb_hgame_match_ctrl;

  localparam int WIN = 3;
  localparam int TMO = 16;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_SCORE = 3, M_DONE = 4;

  typedef struct {
    int st;
    int sc_a, sc_b, sc_c;
    int rounds;
    int winner;
    int res;
    int tmr;
    int grst;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] wd = 3'b000;

  logic       g0, d0, b0, g1, d1, b1;
  logic [1:0] a0, bb0, c0, a1, bb1, c1;
  logic [3:0] r0;
  logic [1:0] r1;
  logic [2:0] w0, w1;

  int tests  = 0;
  int errors = 0;
  mdl_t m0, m1;

  always #5 clk = ~clk;

  hgame_match_ctrl #(.WIN_SCORE(3), .MAX_ROUNDS(9), .TIMEOUT_CYC(16)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .WINNER_DISP(wd),
    .GAME_RST(g0), .SCORE_A(a0), .SCORE_B(bb0), .SCORE_C(c0), .ROUND_CNT(r0),
    .MATCH_WINNER(w0), .MATCH_DONE(d0), .BUSY(b0));

  hgame_match_ctrl #(.WIN_SCORE(3), .MAX_ROUNDS(2), .TIMEOUT_CYC(16)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .WINNER_DISP(wd),
    .GAME_RST(g1), .SCORE_A(a1), .SCORE_B(bb1), .SCORE_C(c1), .ROUND_CNT(r1),
    .MATCH_WINNER(w1), .MATCH_DONE(d1), .BUSY(b1));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic mdl_t reset_m();
    mdl_t n;
    n.st = M_IDLE; n.sc_a = 0; n.sc_b = 0; n.sc_c = 0; n.rounds = 0;
    n.winner = 0; n.res = 0; n.tmr = 0; n.grst = 1;
    return n;
  endfunction

  // One clock of the match rules, written against plain integers.
  function automatic mdl_t step(input mdl_t m, input logic s, input logic a,
                                input logic [2:0] r, input int maxr);
    mdl_t n;
    int mx;
    n = m;
    if (a) begin
      n.st = M_IDLE;
    end else begin
      case (m.st)
        M_IDLE, M_DONE:
          if (s) begin
            n.sc_a = 0; n.sc_b = 0; n.sc_c = 0; n.rounds = 0; n.winner = 0;
            n.st = M_CLEAR;
          end
        M_CLEAR: begin n.st = M_PLAY; n.tmr = 0; end
        M_PLAY:
          if (r != 3'b000) begin n.res = int'(r); n.st = M_SCORE; end
          else if (m.tmr == TMO - 1) begin n.res = 7; n.st = M_SCORE; end
          else n.tmr = m.tmr + 1;
        M_SCORE: begin
          if (m.res != 7) begin
            if ((m.res & 4) != 0) n.sc_a = imin(m.sc_a + 1, WIN);
            if ((m.res & 2) != 0) n.sc_b = imin(m.sc_b + 1, WIN);
            if ((m.res & 1) != 0) n.sc_c = imin(m.sc_c + 1, WIN);
          end
          n.rounds = imin(m.rounds + 1, maxr);
          if (n.sc_a == WIN || n.sc_b == WIN || n.sc_c == WIN || n.rounds == maxr) begin
            n.st = M_DONE;
            mx = n.sc_a;
            if (n.sc_b > mx) mx = n.sc_b;
            if (n.sc_c > mx) mx = n.sc_c;
            n.winner = ((n.sc_a == mx) ? 4 : 0) | ((n.sc_b == mx) ? 2 : 0) |
                       ((n.sc_c == mx) ? 1 : 0);
          end else begin
            n.st = M_CLEAR;
          end
        end
        default: n.st = M_IDLE;
      endcase
    end
    n.grst = (n.st == M_IDLE || n.st == M_CLEAR || n.st == M_DONE) ? 1 : 0;
    return n;
  endfunction

  // Model advances with the DUT clock; reset is asynchronous like the DUT's.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= reset_m();
      m1 <= reset_m();
    end else begin
      m0 <= step(m0, start, abort, wd, 9);
      m1 <= step(m1, start, abort, wd, 2);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("u0.GAME_RST", int'(g0), m0.grst);
    check("u0.SCORE_A", int'(a0), m0.sc_a);
    check("u0.SCORE_B", int'(bb0), m0.sc_b);
    check("u0.SCORE_C", int'(c0), m0.sc_c);
    check("u0.ROUND_CNT", int'(r0), m0.rounds);
    check("u0.MATCH_WINNER", int'(w0), m0.winner);
    check("u0.MATCH_DONE", int'(d0), (m0.st == M_DONE) ? 1 : 0);
    check("u0.BUSY", int'(b0), (m0.st == M_CLEAR || m0.st == M_PLAY || m0.st == M_SCORE) ? 1 : 0);
    check("u1.GAME_RST", int'(g1), m1.grst);
    check("u1.SCORE_A", int'(a1), m1.sc_a);
    check("u1.SCORE_B", int'(bb1), m1.sc_b);
    check("u1.SCORE_C", int'(c1), m1.sc_c);
    check("u1.ROUND_CNT", int'(r1), m1.rounds);
    check("u1.MATCH_WINNER", int'(w1), m1.winner);
    check("u1.MATCH_DONE", int'(d1), (m1.st == M_DONE) ? 1 : 0);
    check("u1.BUSY", int'(b1), (m1.st == M_CLEAR || m1.st == M_PLAY || m1.st == M_SCORE) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) until instance 0 is in a round (round FSM out of reset).
  task automatic wait_play();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (g0 == 1'b0) begin ok = 1'b1; break; end
      tick();
    end
    check("wait_play_timeout", int'(ok), 1);
  endtask

  // Present one result for one PLAY cycle, then step past the SCORE cycle.
  task automatic give_result(input logic [2:0] r);
    wait_play();
    wd = r;
    tick();
    wd = 3'b000;
    tick();
  endtask

  // Let a round stall and count edges until the round FSM is reset again.
  task automatic run_timeout(output int edges);
    wait_play();
    edges = 0;
    while (g0 == 1'b0 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    bit ok;
    rst = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst.GAME_RST", int'(g0), 1);
    check("rst.SCORE_A", int'(a0), 0);
    check("rst.ROUND_CNT", int'(r0), 0);
    check("rst.MATCH_WINNER", int'(w0), 0);
    check("rst.BUSY", int'(b0), 0);
    rst = 1'b0;
    tick();

    // 1: A wins three straight rounds
    pulse_start();
    give_result(3'b100);
    give_result(3'b100);
    give_result(3'b100);
    check("t1.SCORE_A", int'(a0), 3);
    check("t1.ROUND_CNT", int'(r0), 3);
    check("t1.MATCH_WINNER", int'(w0), 3'b100);
    check("t1.GAME_RST", int'(g0), 1);
    check("t1.MATCH_DONE", int'(d0), 1);
    check("t1.u1.SCORE_A", int'(a1), 2);
    check("t1.u1.MATCH_WINNER", int'(w1), 3'b100);

    // 2: shared results, draw adds nothing, then a co-win
    pulse_start();
    check("t2.cleared_A", int'(a0), 0);
    give_result(3'b110);
    give_result(3'b011);
    give_result(3'b101);
    give_result(3'b111);
    check("t2.SCORE_A", int'(a0), 2);
    check("t2.SCORE_B", int'(bb0), 2);
    check("t2.SCORE_C", int'(c0), 2);
    check("t2.ROUND_CNT", int'(r0), 4);
    check("t2.u1.MATCH_WINNER", int'(w1), 3'b010);
    give_result(3'b110);
    check("t2.MATCH_WINNER", int'(w0), 3'b110);
    check("t2.MATCH_DONE", int'(d0), 1);

    // 4a: round limit on the MAX_ROUNDS=2 instance
    pulse_start();
    give_result(3'b100);
    give_result(3'b010);
    check("t4.u1.MATCH_DONE", int'(d1), 1);
    check("t4.u1.SCORE_A", int'(a1), 1);
    check("t4.u1.SCORE_B", int'(bb1), 1);
    check("t4.u1.MATCH_WINNER", int'(w1), 3'b110);

    // 3: stalled round becomes a draw after 16 PLAY cycles
    run_timeout(edges);
    check("t3.edges_to_reset", edges, 17);
    check("t3.ROUND_CNT", int'(r0), 3);
    check("t3.SCORE_A", int'(a0), 1);
    check("t3.SCORE_B", int'(bb0), 1);
    tick();
    check("t3.GAME_RST_pulse_end", int'(g0), 0);

    // 6: result on the timeout cycle is scored
    repeat (15) tick();
    wd = 3'b100;
    tick();
    wd = 3'b000;
    tick();
    check("t6.SCORE_A", int'(a0), 2);
    check("t6.ROUND_CNT", int'(r0), 4);

    // 6b/4b: START mid-round ignored by u0, restarts u1 into an all-draw match
    wait_play();
    pulse_start();
    check("t6.start_ignored_BUSY", int'(b0), 1);
    check("t6.start_ignored_A", int'(a0), 2);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (d1 == 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    check("t4.u1.done_timeout", int'(ok), 1);
    check("t4.u1.draw_MATCH_WINNER", int'(w1), 3'b111);
    check("t4.u1.draw_ROUND_CNT", int'(r1), 2);

    // 5: ABORT mid-round holds scores
    wait_play();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5.GAME_RST", int'(g0), 1);
    check("t5.BUSY", int'(b0), 0);
    check("t5.SCORE_A", int'(a0), 2);
    check("t5.SCORE_B", int'(bb0), 1);

    // 5b: RST during SCORE returns everything to reset values at once
    pulse_start();
    give_result(3'b100);
    wait_play();
    wd = 3'b001;
    tick();
    wd = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    check("t5.rst.SCORE_A", int'(a0), 0);
    check("t5.rst.SCORE_C", int'(c0), 0);
    check("t5.rst.ROUND_CNT", int'(r0), 0);
    check("t5.rst.GAME_RST", int'(g0), 1);
    check("t5.rst.BUSY", int'(b0), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
